div32_seq: RTL and testbench
============================

# div32_seq

Multi-cycle 32-bit restoring divider for the MIPS datapath. It is the subtractive counterpart to the single-cycle carry-lookahead adder. It serves DIV/DIVU by producing a quotient for LO and a remainder for HI. It runs one quotient bit per clock behind a start/busy/done handshake, and the pipeline stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous active-low reset
- `start`  input  1  request; sampled on rising edge, accepted only when `busy`=0
- `is_signed`  input  1  1 = DIV, 0 = DIVU; sampled with `start`
- `dividend`  input  32  sampled with `start`
- `divisor`  input  32  sampled with `start`
- `busy`  output  1  operation in progress
- `done`  output  1  one-cycle pulse; results valid
- `quotient`  output  32  to LO
- `remainder`  output  32  to HI
- `div_by_zero`  output  1  divisor was 0 for the last completed operation

## Operation
- Reset clears every output to 0 and the FSM to IDLE. Reset is asynchronous and takes effect mid-operation; the partial result is discarded.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - On accepted `start`, latch the operands and `is_signed`.
  - Compute magnitudes when signed.
  - Clear the partial remainder and set the step counter to 31.
  - Go to CALC. If `divisor`=0, go to FIX directly.
- CALC, one step per edge:
  - Shift the {remainder, quotient} pair left by 1, bringing in the next dividend bit.
  - Trial-subtract the divisor magnitude from the 33-bit partial remainder.
  - If non-negative, keep the difference and set the quotient LSB to 1; otherwise restore and set it to 0.
  - After the step with counter 0, go to FIX.
- FIX:
  - Negate the quotient if the dividend and divisor signs differ (signed only).
  - The remainder takes the sign of the dividend.
  - Register `quotient`, `remainder` and `div_by_zero`, and pulse `done`.
  - Return to IDLE.
- Divide by zero:
  - `quotient`=32'hFFFFFFFF, `remainder`=dividend (unmodified), `div_by_zero`=1.
  - CALC is skipped.
- Signed overflow (0x80000000 / 0xFFFFFFFF) gives `quotient`=0x80000000, `remainder`=0. No trap or flag.
- `start` while `busy`=1 is ignored. It is not queued and the in-flight operands are unaffected.
- `quotient`, `remainder` and `div_by_zero` hold their values until the next FIX; they do not change during CALC.

## Timing
- E0 is the edge that accepts `start`.
- Normal operation:
  - `busy`=1 from after E0 through E32; CALC steps occur on E1..E32.
  - FIX occurs on E33. After E33: `busy`=0, `done`=1 for exactly one cycle, results valid.
  - Latency is 33 edges from accept to `done`.
- Divide by zero: FIX occurs on E1, and `done`=1 in the cycle after E1 (latency 1).
- `start` may be asserted in the `done` cycle and is accepted on the next edge. Back-to-back throughput is 1 operation per 34 cycles.
- `done` and `busy` are never both 1.

## Configuration
- `DIV32_SIGNED_EN` defined:
  - Signed path compiled in: magnitude conversion, sign fixup in FIX.
  - `is_signed` honoured.
- Undefined:
  - `is_signed` port remains but is ignored.
  - All operations are unsigned and FIX only registers results.
  - Latency is unchanged.

## Test plan
- 100 / 7, unsigned, `start` pulse -> `done` exactly 33 edges after accept; `quotient`=14, `remainder`=2, `div_by_zero`=0.
- 0x12345678 / 0 -> `done` 1 edge after accept; `quotient`=0xFFFFFFFF, `remainder`=0x12345678, `div_by_zero`=1.
- 0xFFFFFFF9 / 2 with `is_signed`=1:
  - With macro: `quotient`=0xFFFFFFFD, `remainder`=0xFFFFFFFF.
  - Without macro: `quotient`=0x7FFFFFFC, `remainder`=1.
- 0x80000000 / 0xFFFFFFFF, signed, macro defined -> `quotient`=0x80000000, `remainder`=0.
- Start 100/7, then pulse `start` with 50/5 at E10 -> second request ignored; results 14/2 at E33. Then 50/5 issued in the `done` cycle -> `quotient`=10, `remainder`=0 after 33 more edges.
- `rst_n` low at E15 of an operation -> all outputs 0 immediately; no `done`. Next `start` after release completes normally.

Source files
------------

// File: rtl/div32_seq.sv
// div32_seq: multi-cycle 32-bit restoring divider for DIV/DIVU, one quotient bit per clock.
// Define DIV32_SIGNED_EN to compile in the signed path; without it is_signed is ignored.
//
//   state | meaning
//   IDLE  | waiting for an accepted start
//   CALC  | one restoring step per edge, cnt_q runs 31..0
//   FIX   | sign fixup, results registered, done pulsed
module div32_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;

  logic             accept;
  logic             dvs_zero;
  logic [WIDTH+1:0] rem_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign accept   = (state_q == S_IDLE) && start;
  assign dvs_zero = (divisor == '0);

`ifdef DIV32_SIGNED_EN
  logic dvd_neg, dvs_neg;
  logic negq_q, negr_q;

  assign dvd_neg = is_signed & dividend[WIDTH-1];
  assign dvs_neg = is_signed & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
  assign quo_fix = negq_q ? -quo_q : quo_q;
  // remainder follows the dividend sign
  assign rem_fix = negr_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else if (accept) begin
      negq_q <= dvd_neg ^ dvs_neg;
      negr_q <= dvd_neg;
    end
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
  assign quo_fix = quo_q;
  assign rem_fix = rem_q[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = dvs_zero ? S_FIX : S_CALC;
      S_CALC: if (cnt_q == '0) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // quo_q doubles as the dividend shift source during CALC
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, dvs_q};

  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    dz_d        = dz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          dz_d  = dvs_zero;
          dvs_d = dvs_mag;
          quo_d = dvs_zero ? dividend : dvd_mag;
          rem_d = '0;
          cnt_d = CW'(WIDTH - 1);
        end
      end
      S_CALC: begin
        quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH+1]};
        rem_d = trial[WIDTH+1] ? rem_sh[WIDTH:0] : trial[WIDTH:0];
        cnt_d = cnt_q - CW'(1);
      end
      S_FIX: begin
        done_d = 1'b1;
        dbz_d  = dz_q;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = quo_q;
        end else begin
          quotient_d  = quo_fix;
          remainder_d = rem_fix;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      dz_q        <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      dz_q        <= dz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      done_q      <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div32_seq.sv
// tb_div32_seq: directed and randomized checks of div32_seq against an arithmetic reference model.
// Honours DIV32_SIGNED_EN the same way as the design.
module tb_div32_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  div32_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

`ifdef DIV32_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          e0;
    int          due;
  } op_t;

  op_t         pend[$];
  int          cyc = 0;
  int          busy_until = 0;
  int          last_e0 = 0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] held_q = '0;
  logic [31:0] held_r = '0;
  logic        held_dz = 1'b0;
  logic        exp_busy, exp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural special cases.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
    int sa, sb;
    dz = (b == 32'd0);
    if (dz) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (SIGNED_EN && s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        sa = $signed(a);
        sb = $signed(b);
        q = 32'(sa / sb);
        r = 32'(sa % sb);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called just after a negedge; the following posedge is the candidate accept edge.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    op_t o;
    logic [31:0] q, r;
    logic dz;
    start     = 1'b1;
    is_signed = s;
    dividend  = a;
    divisor   = b;
    if (cyc >= busy_until) begin
      ref_div(s, a, b, q, r, dz);
      o.q   = q;
      o.r   = r;
      o.dz  = dz;
      o.e0  = cyc + 1;
      o.due = o.e0 + (dz ? 1 : 33);
      busy_until = o.due;
      last_e0    = o.e0;
      pend.push_back(o);
    end
    @(negedge clk);
    start     = 1'b0;
    is_signed = 1'($urandom_range(0, 1));
    dividend  = $urandom;
    divisor   = $urandom;
  endtask

  task automatic wait_done(output int lat);
    bit seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        lat  = cyc - last_e0;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: no done within 60 cycles of accept edge %0d", last_e0);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 255));
      5: return 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Cycle-by-cycle compare: handshake timing and held result registers.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_quotient", quotient, 32'd0);
      chk("rst_remainder", remainder, 32'd0);
      chk("rst_dbz", 32'(div_by_zero), 32'd0);
    end else begin
      exp_busy = 1'b0;
      exp_done = 1'b0;
      if (pend.size() != 0) begin
        if (cyc >= pend[0].e0 && cyc < pend[0].due) exp_busy = 1'b1;
        if (cyc == pend[0].due) begin
          exp_done = 1'b1;
          held_q   = pend[0].q;
          held_r   = pend[0].r;
          held_dz  = pend[0].dz;
          void'(pend.pop_front());
        end
      end
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("quotient", quotient, held_q);
      chk("remainder", remainder, held_r);
      chk("div_by_zero", 32'(div_by_zero), 32'(held_dz));
    end
  end

  initial begin
    int          lat;
    int          e0;
    logic [31:0] mq, mr;
    logic        mdz;
    logic        s;
    logic [31:0] a, b;

    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);

    chk("post_reset_quotient", quotient, 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    ref_div(1'b0, 32'd100, 32'd7, mq, mr, mdz);
    chk("model_100_7_q", mq, 32'd14);
    chk("model_100_7_r", mr, 32'd2);
    ref_div(1'b0, 32'd50, 32'd0, mq, mr, mdz);
    chk("model_dz_q", mq, 32'hFFFF_FFFF);
    chk("model_dz_r", mr, 32'd50);

    issue(1'b0, 32'd100, 32'd7);
    wait_done(lat);
    chk("lat_100_7", 32'(lat), 32'd33);
    chk("q_100_7", quotient, 32'd14);
    chk("r_100_7", remainder, 32'd2);
    chk("dz_100_7", 32'(div_by_zero), 32'd0);

    @(negedge clk);
    issue(1'b0, 32'h1234_5678, 32'd0);
    wait_done(lat);
    chk("lat_dz", 32'(lat), 32'd1);
    chk("q_dz", quotient, 32'hFFFF_FFFF);
    chk("r_dz", remainder, 32'h1234_5678);
    chk("dz_dz", 32'(div_by_zero), 32'd1);

    @(negedge clk);
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat);
`ifdef DIV32_SIGNED_EN
    chk("q_m7_2", quotient, 32'hFFFF_FFFD);
    chk("r_m7_2", remainder, 32'hFFFF_FFFF);
`else
    chk("q_m7_2", quotient, 32'h7FFF_FFFC);
    chk("r_m7_2", remainder, 32'd1);
`endif

`ifdef DIV32_SIGNED_EN
    @(negedge clk);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat);
    chk("q_ovf", quotient, 32'h8000_0000);
    chk("r_ovf", remainder, 32'd0);
`endif

    // start during busy is dropped; a start in the done cycle is taken
    @(negedge clk);
    issue(1'b0, 32'd100, 32'd7);
    e0 = last_e0;
    while (cyc < e0 + 9) @(negedge clk);
    issue(1'b0, 32'd50, 32'd5);
    wait_done(lat);
    chk("lat_ignored", 32'(lat), 32'd33);
    chk("q_ignored", quotient, 32'd14);
    chk("r_ignored", remainder, 32'd2);
    issue(1'b0, 32'd50, 32'd5);
    wait_done(lat);
    chk("lat_b2b", 32'(lat), 32'd33);
    chk("q_b2b", quotient, 32'd10);
    chk("r_b2b", remainder, 32'd0);

    // asynchronous reset after E15
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd3);
    e0 = last_e0;
    while (cyc < e0 + 14) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    pend.delete();
    busy_until = 0;
    held_q  = '0;
    held_r  = '0;
    held_dz = 1'b0;
    #1;
    chk("async_rst_quotient", quotient, 32'd0);
    chk("async_rst_remainder", remainder, 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'd1000, 32'd3);
    wait_done(lat);
    chk("lat_after_rst", 32'(lat), 32'd33);
    chk("q_after_rst", quotient, 32'd333);
    chk("r_after_rst", remainder, 32'd1);

    for (int n = 0; n < 200; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      issue(s, a, b);
      if (b != 32'd0 && $urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        issue(~s, $urandom, $urandom);
      end
      wait_done(lat);
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
